// File: rtl/matmul_engine.sv
// Matrix-multiply engine: Y = A*X with N_CH parallel MAC lanes, A from a registered
// coefficient ROM, X streamed in, results written one word per cycle to SRAM.
module matmul_engine #(
    parameter int X_W    = 8,
    parameter int A_W    = 14,
    parameter int N_CH   = 4,
    parameter int K      = 4,
    parameter int N_ROW  = 4,
    parameter int RAM_AW = 8,
    parameter int RAM_DW = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          signed_mode,
    input  logic [RAM_AW-1:0]             base_addr,
    input  logic                          x_valid,
    input  logic [X_W-1:0]                x_data,
    output logic                          x_ready,
    output logic [$clog2(N_ROW*K)-1:0]    rom_addr,
    input  logic [A_W-1:0]                rom_data,
    output logic                          ram_we_n,
    output logic [RAM_AW-1:0]             ram_addr,
    output logic [RAM_DW-1:0]             ram_wdata,
    output logic                          busy,
    output logic                          done
);
    localparam int ACC_W = X_W + A_W + $clog2(K);
    localparam int NX    = K * N_CH;
    localparam int EW    = $clog2(NX + 1);
    localparam int JW    = $clog2(K + 1);
    localparam int CW    = $clog2(N_CH + 1);
    localparam int RW    = $clog2(N_ROW + 1);
    localparam int AAW   = $clog2(N_ROW * K);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    if (ACC_W > RAM_DW) begin : g_acc_too_wide
        $error("matmul_engine: ACC_W exceeds RAM_DW");
    end

    logic [2:0]                state;
    logic                      sgn_q;
    logic [RAM_AW-1:0]         base_q;
    logic [EW-1:0]             elem_cnt;
    logic [JW-1:0]             j_cnt;
    logic [CW-1:0]             c_cnt;
    logic [RW-1:0]             row_cnt;
    logic [NX*X_W-1:0]         x_store;
    logic signed [ACC_W-1:0]   acc     [N_CH];
    logic signed [ACC_W-1:0]   acc_nxt [N_CH];
    logic [X_W-1:0]            x_sel   [N_CH];
    logic signed [ACC_W-1:0]   wb_next;

    // Operands are widened to the accumulator width before multiplying; the true
    // product always fits, so the truncated product is exact.
    function automatic logic signed [ACC_W-1:0] mac_term(input logic [X_W-1:0] x,
                                                         input logic [A_W-1:0] a,
                                                         input logic sgn);
        logic signed [ACC_W-1:0] xs;
        logic signed [ACC_W-1:0] as;
        xs = ACC_W'($signed({sgn & x[X_W-1], x}));
        as = ACC_W'($signed({sgn & a[A_W-1], a}));
        return xs * as;
    endfunction

    function automatic logic [RAM_DW-1:0] ext_acc(input logic signed [ACC_W-1:0] a,
                                                  input logic sgn);
        if (sgn)
            return RAM_DW'(a);
        else
            return RAM_DW'($unsigned(a));
    endfunction

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            x_sel[c] = '0;
            for (int k = 0; k < K; k++)
                if (j_cnt == JW'(k + 1))
                    x_sel[c] = x_store[(k*N_CH + c)*X_W +: X_W];
            acc_nxt[c] = acc[c] + mac_term(x_sel[c], rom_data, sgn_q);
        end
        wb_next = '0;
        for (int c = 1; c < N_CH; c++)
            if (c_cnt == CW'(c - 1))
                wb_next = acc[c];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sgn_q     <= 1'b0;
            base_q    <= '0;
            elem_cnt  <= '0;
            j_cnt     <= '0;
            c_cnt     <= '0;
            row_cnt   <= '0;
            x_store   <= '0;
            for (int c = 0; c < N_CH; c++)
                acc[c] <= '0;
            x_ready   <= 1'b0;
            rom_addr  <= '0;
            ram_we_n  <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sgn_q    <= signed_mode;
                        base_q   <= base_addr;
                        elem_cnt <= '0;
                        row_cnt  <= '0;
                        j_cnt    <= '0;
                        c_cnt    <= '0;
                        x_ready  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (x_valid) begin
                        x_store <= {x_data, x_store[NX*X_W-1:X_W]};
                        if (elem_cnt == EW'(NX - 1)) begin
                            x_ready  <= 1'b0;
                            j_cnt    <= '0;
                            rom_addr <= '0;
                            state    <= S_MAC;
                        end else begin
                            elem_cnt <= elem_cnt + EW'(1);
                        end
                    end
                end
                // ROM address leads the accumulate by one cycle to cover the ROM register.
                S_MAC: begin
                    for (int c = 0; c < N_CH; c++)
                        acc[c] <= (j_cnt == '0) ? '0 : acc_nxt[c];
                    if (int'(j_cnt) + 1 < K)
                        rom_addr <= AAW'(int'(row_cnt)*K + int'(j_cnt) + 1);
                    if (j_cnt == JW'(K)) begin
                        c_cnt     <= '0;
                        ram_we_n  <= 1'b0;
                        ram_addr  <= base_q + RAM_AW'(int'(row_cnt)*N_CH);
                        ram_wdata <= ext_acc(acc_nxt[0], sgn_q);
                        state     <= S_WB;
                    end else begin
                        j_cnt <= j_cnt + JW'(1);
                    end
                end
                S_WB: begin
                    if (c_cnt == CW'(N_CH - 1)) begin
                        ram_we_n <= 1'b1;
                        if (row_cnt == RW'(N_ROW - 1)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            row_cnt  <= row_cnt + RW'(1);
                            j_cnt    <= '0;
                            rom_addr <= AAW'((int'(row_cnt) + 1)*K);
                            state    <= S_MAC;
                        end
                    end else begin
                        c_cnt     <= c_cnt + CW'(1);
                        ram_addr  <= ram_addr + RAM_AW'(1);
                        ram_wdata <= ext_acc(wb_next, sgn_q);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: uniform, signed, maximum, mixed, wrap and control cases.
module tb_matmul_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [7:0]  base_addr;
    logic        x_valid;
    logic [7:0]  x_data;
    logic        x_ready;
    logic [3:0]  rom_addr;
    logic [13:0] rom_data;
    logic        ram_we_n;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        busy;
    logic        done;

    logic [7:0]  xv    [16];
    logic [13:0] a_mem [16];
    int          n_chk  = 0;
    int          n_pass = 0;

    matmul_engine dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .base_addr(base_addr), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .ram_we_n(ram_we_n),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered coefficient ROM
    always @(posedge clk) rom_data <= a_mem[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic fill(input logic [7:0] xval, input logic [13:0] aval, input bit mixed);
        for (int i = 0; i < 16; i++) begin
            xv[i]    = mixed ? 8'(i + 1) : xval;
            a_mem[i] = mixed ? 14'(i / 4 + 1) : aval;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_x_ready"},  32'(x_ready),  32'd0);
        check_eq({tag, "_busy"},     32'(busy),     32'd0);
        check_eq({tag, "_done"},     32'(done),     32'd0);
        check_eq({tag, "_we_n"},     32'(ram_we_n), 32'd1);
        check_eq({tag, "_addr"},     32'(ram_addr), 32'd0);
        check_eq({tag, "_wdata"},    ram_wdata,     32'd0);
        check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    // mixed=1: Y[r][c] = (r+1)*(28+4c); otherwise every result equals kval.
    task automatic run_job(input string name, input logic sgn, input logic [7:0] base,
                           input bit mixed, input logic [31:0] kval, input bit gaps,
                           input bit pulses, input int rst_at);
        int n, idx, nwr, last_wr, done_cyc;
        bit got_done, aborted;
        logic [7:0]  ea;
        logic [31:0] ed;
        n = 0; idx = 0; nwr = 0; last_wr = -1; done_cyc = -1;
        got_done = 0; aborted = 0;
        @(negedge clk);
        while (n < 400) begin
            if (n == 0) begin
                check_eq({name, "_c0_x_ready"}, 32'(x_ready), 32'd0);
                check_eq({name, "_c0_busy"},    32'(busy),    32'd0);
            end
            if (n == 1) begin
                check_eq({name, "_c1_x_ready"}, 32'(x_ready), 32'd1);
                check_eq({name, "_c1_busy"},    32'(busy),    32'd1);
            end
            if (!ram_we_n) begin
                ea = base + 8'(nwr);
                ed = mixed ? 32'((nwr / 4 + 1) * (28 + 4 * (nwr % 4))) : kval;
                check_eq($sformatf("%s_wr%0d_addr", name, nwr), 32'(ram_addr), 32'(ea));
                check_eq($sformatf("%s_wr%0d_data", name, nwr), ram_wdata, ed);
                nwr++;
                last_wr = n;
            end
            if (done) begin
                got_done = 1;
                done_cyc = n;
            end
            if (n == rst_at) begin
                rst = 1'b0;
                #1;
                check_reset_outputs({name, "_midrst"});
                x_valid = 1'b0;
                start   = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                aborted = 1;
                break;
            end
            x_valid     = (idx < 16) && (!gaps || ($urandom_range(0, 2) != 0));
            x_data      = xv[(idx < 16) ? idx : 0];
            if (x_ready && x_valid) idx++;
            start       = (n == 0) || (pulses && (n == 5 || n == 19 || n == 23 || n == 53));
            signed_mode = (n == 0) ? sgn : ~sgn;
            base_addr   = (n == 0) ? base : ~base;
            if (got_done) break;
            @(negedge clk);
            n++;
        end
        if (!aborted) begin
            if (!got_done) begin
                check_eq({name, "_done_timeout"}, 32'd0, 32'd1);
            end else begin
                check_eq({name, "_nwrites"},   32'(nwr), 32'd16);
                check_eq({name, "_done_gap"},  32'(done_cyc - last_wr), 32'd1);
                if (!gaps) begin
                    check_eq({name, "_done_cyc"}, 32'(done_cyc), 32'd53);
                    check_eq({name, "_last_wr"},  32'(last_wr),  32'd52);
                end
                @(negedge clk);
                check_eq({name, "_busy_end"}, 32'(busy), 32'd0);
                check_eq({name, "_done_end"}, 32'(done), 32'd0);
            end
        end
        start   = 1'b0;
        x_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; signed_mode = 1'b0; base_addr = 8'h00;
        x_valid = 1'b0; x_data = 8'h00;
        fill(8'h00, 14'h0000, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        fill(8'h01, 14'h0002, 1'b0);
        run_job("uns_uniform", 1'b0, 8'h00, 1'b0, 32'h0000_0008, 1'b0, 1'b0, -1);
        fill(8'hFF, 14'h3FFF, 1'b0);
        run_job("sgn_neg", 1'b1, 8'h00, 1'b0, 32'h0000_0004, 1'b0, 1'b0, -1);
        fill(8'h80, 14'h2000, 1'b0);
        run_job("sgn_min", 1'b1, 8'h00, 1'b0, 32'h0040_0000, 1'b0, 1'b0, -1);
        fill(8'hFF, 14'h0002, 1'b0);
        run_job("sgn_negres", 1'b1, 8'h30, 1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0, -1);
        fill(8'hFF, 14'h3FFF, 1'b0);
        run_job("uns_max", 1'b0, 8'h00, 1'b0, 32'h00FE_FC04, 1'b0, 1'b0, -1);
        fill(8'h00, 14'h0000, 1'b1);
        run_job("mixed_gaps", 1'b0, 8'h10, 1'b1, 32'h0, 1'b1, 1'b0, -1);
        run_job("wrap", 1'b0, 8'hF8, 1'b1, 32'h0, 1'b0, 1'b0, -1);
        fill(8'h01, 14'h0002, 1'b0);
        run_job("start_pulses", 1'b0, 8'h40, 1'b0, 32'h0000_0008, 1'b0, 1'b1, -1);
        fill(8'h00, 14'h0000, 1'b1);
        run_job("rst_mid_wb", 1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0, 23);
        run_job("after_rst", 1'b0, 8'h20, 1'b1, 32'h0, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
